// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - byte-serialising big-endian load/store sequencer for a byte-wide sync-read RAM
// Optional misaligned-request trap: define DATA_MEM_MISALIGN_CHECK_EN.
module data_mem_ctrl #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        RDLAST,
        RESP
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [1:0]          nm1_q, nm1_d;      // byte count minus one: 0, 1 or 3
    logic [1:0]          k_q, k_d;
    logic                sgn_q, sgn_d;
    logic                wr_q, wr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         acc_q, acc_d;
    logic                rd_pend_q, rd_pend_d;
    logic [1:0]          byte_sel;
    logic [31:0]         ext_data;
    logic                unused_addr_hi;

    assign unused_addr_hi = ^req_addr[31:ADDR_W];

`ifdef DATA_MEM_MISALIGN_CHECK_EN
    logic err_q, err_d;
    logic misaligned;

    assign misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                        (req_size[1] && (req_addr[1:0] != 2'b00));
    assign resp_err   = (state_q == RESP) && err_q;
`else
    assign resp_err   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            nm1_q     <= 2'd0;
            k_q       <= 2'd0;
            sgn_q     <= 1'b0;
            wr_q      <= 1'b0;
            wdata_q   <= 32'd0;
            acc_q     <= 32'd0;
            rd_pend_q <= 1'b0;
`ifdef DATA_MEM_MISALIGN_CHECK_EN
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            nm1_q     <= nm1_d;
            k_q       <= k_d;
            sgn_q     <= sgn_d;
            wr_q      <= wr_d;
            wdata_q   <= wdata_d;
            acc_q     <= acc_d;
            rd_pend_q <= rd_pend_d;
`ifdef DATA_MEM_MISALIGN_CHECK_EN
            err_q     <= err_d;
`endif
        end
    end

    // Big-endian: byte k of an N-byte access is data byte N-1-k.
    assign byte_sel = nm1_q - k_q;

    always_comb begin
        ext_data = acc_q;
        case (nm1_q)
            2'd0:    ext_data = {{24{sgn_q & acc_q[7]}}, acc_q[7:0]};
            2'd1:    ext_data = {{16{sgn_q & acc_q[15]}}, acc_q[15:0]};
            default: ext_data = acc_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        nm1_d      = nm1_q;
        k_d        = k_q;
        sgn_d      = sgn_q;
        wr_d       = wr_q;
        wdata_d    = wdata_q;
        rd_pend_d  = 1'b0;
        // A read issued last cycle has its byte on mem_rdata now.
        acc_d      = rd_pend_q ? {acc_q[23:0], mem_rdata} : acc_q;
`ifdef DATA_MEM_MISALIGN_CHECK_EN
        err_d      = err_q;
`endif
        req_ready  = (state_q == IDLE);
        resp_valid = 1'b0;
        resp_rdata = 32'd0;
        mem_addr   = '0;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        mem_wdata  = 8'd0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr[ADDR_W-1:0];
                    sgn_d   = req_signed;
                    wr_d    = req_write;
                    wdata_d = req_wdata;
                    k_d     = 2'd0;
                    acc_d   = 32'd0;
                    case (req_size)
                        2'b00:   nm1_d = 2'd0;
                        2'b01:   nm1_d = 2'd1;
                        default: nm1_d = 2'd3;
                    endcase
                    state_d = XFER;
`ifdef DATA_MEM_MISALIGN_CHECK_EN
                    err_d   = misaligned;
                    if (misaligned) begin
                        state_d = RESP;
                    end
`endif
                end
            end
            XFER: begin
                mem_addr = addr_q + ADDR_W'(k_q);
                if (wr_q) begin
                    mem_we    = 1'b1;
                    mem_wdata = wdata_q[{byte_sel, 3'b000} +: 8];
                end else begin
                    mem_re    = 1'b1;
                    rd_pend_d = 1'b1;
                end
                k_d = k_q + 2'd1;
                if (k_q == nm1_q) begin
                    state_d = wr_q ? RESP : RDLAST;
                end
            end
            RDLAST: begin
                state_d = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_rdata = ext_data;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
